sound_latch_ctrl: RTL and testbench

- Mailbox controller between the main 68000 and the sound 68000.
- Holds the two 16-bit command/reply latches: latch0 carries main→sound, latch1 carries sound→main.
- Tracks a pending flag per latch and raises the sound CPU level-4 interrupt when the main CPU posts a command.
- Driven by the latch chip-selects from the address decoder and by raw bus strobes. Each bus cycle commits exactly once, however many clocks it lasts.

---
 rtl/sound_latch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sound_latch_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_latch_ctrl.sv
// Mailbox between the main and sound 68000s: two 16-bit latches with pending
// flags and a level-4 interrupt toward the sound CPU.
module sound_latch_ctrl #(
   parameter int DW           = 16,
   parameter bit IRQ_ON_WRITE = 1'b1,
   parameter bit CLR_ON_READ  = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m68kp_latch0_cs,
   input  logic          m68kp_latch1_cs,
   input  logic          m68kp_as_n,
   input  logic          m68kp_rw,
   input  logic          m68kp_uds_n,
   input  logic          m68kp_lds_n,
   input  logic [DW-1:0] m68kp_din,
   output logic [DW-1:0] m68kp_dout,
   input  logic          m68ks_latch0_cs,
   input  logic          m68ks_latch1_cs,
   input  logic          m68ks_as_n,
   input  logic          m68ks_rw,
   input  logic          m68ks_uds_n,
   input  logic          m68ks_lds_n,
   input  logic [DW-1:0] m68ks_din,
   output logic [DW-1:0] m68ks_dout,
   input  logic          m68ks_iack,
   output logic          sound_irq,
   output logic          pend0,
   output logic          pend1
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   // Access indices: main/latch0, main/latch1, sound/latch0, sound/latch1
   localparam int A_M0  = 0;
   localparam int A_M1  = 1;
   localparam int A_S0  = 2;
   localparam int A_S1  = 3;
   localparam int NLANE = DW / 8;

   logic [3:0]       acc;
   logic [3:0]       acc_q_reg;
   logic [3:0]       armed_reg;
   logic [3:0]       rise;
   logic             fall_m1;
   logic             fall_s0;
   logic [NLANE-1:0] m_strb;
   logic [NLANE-1:0] s_strb;

   logic             wr0;
   logic             wr1;
   logic             cap_m;
   logic             cap_s;
   logic             clr0;
   logic             clr1;
   logic             iack_q_reg;
   logic             iack_rise;

   logic [DW-1:0]    latch0_reg, latch0_next;
   logic [DW-1:0]    latch1_reg, latch1_next;
   logic [DW-1:0]    dout_m_reg, dout_m_next;
   logic [DW-1:0]    dout_s_reg, dout_s_next;
   logic             pend0_reg, pend0_next;
   logic             pend1_reg, pend1_next;
   logic             rd_m1_reg, rd_m1_next;
   logic             rd_s0_reg, rd_s0_next;
   logic [0:0]       state_reg, state_next;

   assign m_strb = {~m68kp_uds_n, ~m68kp_lds_n};
   assign s_strb = {~m68ks_uds_n, ~m68ks_lds_n};

   assign acc[A_M0] = m68kp_latch0_cs & ~m68kp_as_n & (|m_strb);
   assign acc[A_M1] = m68kp_latch1_cs & ~m68kp_as_n & (|m_strb);
   assign acc[A_S0] = m68ks_latch0_cs & ~m68ks_as_n & (|s_strb);
   assign acc[A_S1] = m68ks_latch1_cs & ~m68ks_as_n & (|s_strb);

   // An access only counts once it has been seen idle after reset, so a bus
   // cycle straddling reset release neither commits nor clears anything.
   assign rise    = acc & ~acc_q_reg & armed_reg;
   assign fall_m1 = ~acc[A_M1] & acc_q_reg[A_M1] & armed_reg[A_M1];
   assign fall_s0 = ~acc[A_S0] & acc_q_reg[A_S0] & armed_reg[A_S0];

   // Writes only land in the latch the CPU produces; the other one is read-only
   assign wr0   = rise[A_M0] & ~m68kp_rw;
   assign wr1   = rise[A_S1] & ~m68ks_rw;
   assign cap_m = (rise[A_M0] | rise[A_M1]) & m68kp_rw;
   assign cap_s = (rise[A_S0] | rise[A_S1]) & m68ks_rw;

   // The cycle type is frozen at the rising edge; rw may wander afterwards
   assign rd_m1_next = rise[A_M1] ? m68kp_rw : rd_m1_reg;
   assign rd_s0_next = rise[A_S0] ? m68ks_rw : rd_s0_reg;

   assign clr0 = CLR_ON_READ & fall_s0 & rd_s0_reg;
   assign clr1 = CLR_ON_READ & fall_m1 & rd_m1_reg;

   generate
      for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
         assign latch0_next[8*gi +: 8] = (wr0 && m_strb[gi]) ? m68kp_din[8*gi +: 8]
                                                             : latch0_reg[8*gi +: 8];
         assign latch1_next[8*gi +: 8] = (wr1 && s_strb[gi]) ? m68ks_din[8*gi +: 8]
                                                             : latch1_reg[8*gi +: 8];
      end
   endgenerate

   assign dout_m_next = cap_m ? (rise[A_M1] ? latch1_reg : latch0_reg) : dout_m_reg;
   assign dout_s_next = cap_s ? (rise[A_S1] ? latch1_reg : latch0_reg) : dout_s_reg;

   // A set in the same clock as a clear wins so a fresh command is never lost
   assign pend0_next = wr0 | (pend0_reg & ~clr0);
   assign pend1_next = wr1 | (pend1_reg & ~clr1);

   assign iack_rise = m68ks_iack & ~iack_q_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (wr0 && IRQ_ON_WRITE) state_next = ST_REQ;
         ST_REQ: begin
            if (wr0 && IRQ_ON_WRITE) state_next = ST_REQ;
            else if (iack_rise)      state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q_reg  <= '0;
         armed_reg  <= '0;
         iack_q_reg <= 1'b0;
         latch0_reg <= '0;
         latch1_reg <= '0;
         dout_m_reg <= '0;
         dout_s_reg <= '0;
         pend0_reg  <= 1'b0;
         pend1_reg  <= 1'b0;
         rd_m1_reg  <= 1'b0;
         rd_s0_reg  <= 1'b0;
         state_reg  <= ST_IDLE;
      end else begin
         acc_q_reg  <= acc;
         armed_reg  <= armed_reg | ~acc;
         iack_q_reg <= m68ks_iack;
         latch0_reg <= latch0_next;
         latch1_reg <= latch1_next;
         dout_m_reg <= dout_m_next;
         dout_s_reg <= dout_s_next;
         pend0_reg  <= pend0_next;
         pend1_reg  <= pend1_next;
         rd_m1_reg  <= rd_m1_next;
         rd_s0_reg  <= rd_s0_next;
         state_reg  <= state_next;
      end
   end

   assign m68kp_dout = dout_m_reg;
   assign m68ks_dout = dout_s_reg;
   assign pend0      = pend0_reg;
   assign pend1      = pend1_reg;
   assign sound_irq  = (state_reg == ST_REQ);

endmodule

// File: tb/tb_sound_latch_ctrl.sv
// Scoreboard bench for sound_latch_ctrl: two instances (default parameters and
// IRQ_ON_WRITE=0/CLR_ON_READ=0) share one pair of buses and one mailbox model.
module tb_sound_latch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_cs0, m_cs1, m_as_n, m_rw, m_uds_n, m_lds_n;
   logic [15:0] m_din;
   logic        s_cs0, s_cs1, s_as_n, s_rw, s_uds_n, s_lds_n, s_iack;
   logic [15:0] s_din;
   logic [15:0] dout_p0, dout_s0, dout_p1, dout_s1;
   logic        irq0, irq1, p0_0, p1_0, p0_1, p1_1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sound_latch_ctrl u_a (
      .clk(clk), .reset(reset),
      .m68kp_latch0_cs(m_cs0), .m68kp_latch1_cs(m_cs1), .m68kp_as_n(m_as_n),
      .m68kp_rw(m_rw), .m68kp_uds_n(m_uds_n), .m68kp_lds_n(m_lds_n),
      .m68kp_din(m_din), .m68kp_dout(dout_p0),
      .m68ks_latch0_cs(s_cs0), .m68ks_latch1_cs(s_cs1), .m68ks_as_n(s_as_n),
      .m68ks_rw(s_rw), .m68ks_uds_n(s_uds_n), .m68ks_lds_n(s_lds_n),
      .m68ks_din(s_din), .m68ks_dout(dout_s0), .m68ks_iack(s_iack),
      .sound_irq(irq0), .pend0(p0_0), .pend1(p1_0)
   );

   sound_latch_ctrl #(.DW(16), .IRQ_ON_WRITE(1'b0), .CLR_ON_READ(1'b0)) u_b (
      .clk(clk), .reset(reset),
      .m68kp_latch0_cs(m_cs0), .m68kp_latch1_cs(m_cs1), .m68kp_as_n(m_as_n),
      .m68kp_rw(m_rw), .m68kp_uds_n(m_uds_n), .m68kp_lds_n(m_lds_n),
      .m68kp_din(m_din), .m68kp_dout(dout_p1),
      .m68ks_latch0_cs(s_cs0), .m68ks_latch1_cs(s_cs1), .m68ks_as_n(s_as_n),
      .m68ks_rw(s_rw), .m68ks_uds_n(s_uds_n), .m68ks_lds_n(s_lds_n),
      .m68ks_din(s_din), .m68ks_dout(dout_s1), .m68ks_iack(s_iack),
      .sound_irq(irq1), .pend0(p0_1), .pend1(p1_1)
   );

   // Mailbox model, index [k] = instance (0: irq+clear-on-read, 1: neither)
   logic [15:0] mdl_lat [2][2];
   bit          mdl_pend[2][2];
   bit          mdl_irq [2];
   logic [15:0] mdl_dp  [2];
   logic [15:0] mdl_ds  [2];

   typedef struct { string name; logic [15:0] e0; logic [15:0] e1; } rd_t;
   typedef struct {
      string name;
      logic [15:0] dp0, dp1, ds0, ds1;
      logic [2:0]  f0, f1;
   } st_t;
   rd_t rq_m[$];
   rd_t rq_s[$];
   st_t sq[$];
   event st_ev;
   bit m_prev = 1'b1;
   bit s_prev = 1'b1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mdl_lat[k][0] = '0; mdl_lat[k][1] = '0;
         mdl_pend[k][0] = 0; mdl_pend[k][1] = 0;
         mdl_irq[k] = 0; mdl_dp[k] = '0; mdl_ds[k] = '0;
      end
   endtask

   task automatic idle_main();
      m_cs0 = 0; m_cs1 = 0; m_as_n = 1; m_rw = 1; m_uds_n = 1; m_lds_n = 1;
   endtask

   task automatic idle_sound();
      s_cs0 = 0; s_cs1 = 0; s_as_n = 1; s_rw = 1; s_uds_n = 1; s_lds_n = 1;
   endtask

   task automatic check_status(input string tag);
      st_t s;
      @(negedge clk);
      s.name = tag;
      s.dp0 = mdl_dp[0]; s.dp1 = mdl_dp[1]; s.ds0 = mdl_ds[0]; s.ds1 = mdl_ds[1];
      s.f0 = {mdl_pend[0][0], mdl_pend[0][1], mdl_irq[0]};
      s.f1 = {mdl_pend[1][0], mdl_pend[1][1], mdl_irq[1]};
      sq.push_back(s);
      -> st_ev;
   endtask

   // Model effect of a producer write; consumer-side writes are ignored
   task automatic model_write(input bit side, input bit lat, input bit uds_n,
                              input bit lds_n, input logic [15:0] d);
      if (side != lat) return;
      for (int k = 0; k < 2; k++) begin
         if (!uds_n) mdl_lat[k][lat][15:8] = d[15:8];
         if (!lds_n) mdl_lat[k][lat][7:0]  = d[7:0];
         mdl_pend[k][lat] = 1;
         if (lat == 0 && k == 0) mdl_irq[k] = 1;
      end
   endtask

   task automatic model_read(input bit side, input bit lat, input string tag);
      rd_t r;
      for (int k = 0; k < 2; k++) begin
         if (side) mdl_ds[k] = mdl_lat[k][lat];
         else      mdl_dp[k] = mdl_lat[k][lat];
      end
      r.name = tag;
      r.e0 = side ? mdl_ds[0] : mdl_dp[0];
      r.e1 = side ? mdl_ds[1] : mdl_dp[1];
      if (side) rq_s.push_back(r);
      else      rq_m.push_back(r);
   endtask

   task automatic drive(input bit side, input bit lat, input bit rw, input bit uds_n,
                        input bit lds_n, input logic [15:0] d);
      if (!side) begin
         m_cs0 = !lat; m_cs1 = lat; m_rw = rw; m_uds_n = uds_n; m_lds_n = lds_n;
         m_din = d; m_as_n = 0;
      end else begin
         s_cs0 = !lat; s_cs1 = lat; s_rw = rw; s_uds_n = uds_n; s_lds_n = lds_n;
         s_din = d; s_as_n = 0;
      end
   endtask

   task automatic bus_cycle(input bit side, input bit lat, input bit rw, input bit uds_n,
                            input bit lds_n, input logic [15:0] d, input int hold,
                            input bit vary, input bit mid, input string tag);
      @(negedge clk);
      drive(side, lat, rw, uds_n, lds_n, d);
      $display("txn %-10s %s %s latch%0d data=%h uds_n=%0d lds_n=%0d hold=%0d",
               tag, side ? "sound" : "main ", rw ? "rd" : "wr", lat, d, uds_n, lds_n, hold);
      if (rw) model_read(side, lat, tag);
      else    model_write(side, lat, uds_n, lds_n, d);
      for (int i = 0; i < hold; i++) begin
         if (i == 0 && mid) check_status({tag, "_mid"});
         else               @(negedge clk);
         if (vary) begin
            if (side) s_din = 16'($urandom);
            else      m_din = 16'($urandom);
         end
      end
      if (side) idle_sound();
      else      idle_main();
      if (rw && side != lat) mdl_pend[0][lat] = 0;
   endtask

   task automatic iack_pulse();
      @(negedge clk);
      s_iack = 1;
      mdl_irq[0] = 0; mdl_irq[1] = 0;
      $display("txn iack");
      @(negedge clk);
      s_iack = 0;
   endtask

   // Read monitors: a read cycle start is followed one clock later by dout
   initial forever begin
      rd_t r;
      @(posedge clk);
      if (!m_as_n && m_prev && m_rw && !reset) begin
         m_prev = m_as_n;
         @(negedge clk);
         if (rq_m.size() == 0) begin
            checks++; errors++;
            $display("FAIL main_read_unexpected: got %h expected none", dout_p0);
         end else begin
            r = rq_m.pop_front();
            chk({r.name, "_dout_main_a"}, dout_p0, r.e0);
            chk({r.name, "_dout_main_b"}, dout_p1, r.e1);
         end
      end else m_prev = m_as_n;
   end

   initial forever begin
      rd_t r;
      @(posedge clk);
      if (!s_as_n && s_prev && s_rw && !reset) begin
         s_prev = s_as_n;
         @(negedge clk);
         if (rq_s.size() == 0) begin
            checks++; errors++;
            $display("FAIL sound_read_unexpected: got %h expected none", dout_s0);
         end else begin
            r = rq_s.pop_front();
            chk({r.name, "_dout_snd_a"}, dout_s0, r.e0);
            chk({r.name, "_dout_snd_b"}, dout_s1, r.e1);
         end
      end else s_prev = s_as_n;
   end

   initial forever begin
      st_t s;
      @(st_ev);
      while (sq.size() > 0) begin
         s = sq.pop_front();
         chk({s.name, "_flags_a"}, {13'd0, p0_0, p1_0, irq0}, {13'd0, s.f0});
         chk({s.name, "_flags_b"}, {13'd0, p0_1, p1_1, irq1}, {13'd0, s.f1});
         chk({s.name, "_dp_a"}, dout_p0, s.dp0);
         chk({s.name, "_dp_b"}, dout_p1, s.dp1);
         chk({s.name, "_ds_a"}, dout_s0, s.ds0);
         chk({s.name, "_ds_b"}, dout_s1, s.ds1);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bit side, lat, rw;
      int st;
      reset = 1; s_iack = 0; m_din = '0; s_din = '0;
      idle_main(); idle_sound(); model_reset();
      repeat (3) @(negedge clk);
      reset = 0;
      check_status("reset");

      // Reset lands in the middle of a main latch0 write
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 16'h1111);
      model_write(0, 0, 0, 0, 16'h1111);
      $display("txn pre_reset  main  wr latch0 data=1111 (reset mid-cycle)");
      @(negedge clk);
      check_status("pre_reset");
      #2 reset = 1;
      model_reset();
      check_status("in_reset");
      reset = 0;
      repeat (3) @(negedge clk);
      idle_main();
      check_status("post_reset");
      bus_cycle(1, 0, 1, 0, 0, 16'h0, 2, 0, 0, "rst_rd");

      // Command round trip
      bus_cycle(0, 0, 0, 0, 0, 16'h1234, 4, 0, 1, "cmd");
      check_status("cmd");
      iack_pulse();
      check_status("iack");
      bus_cycle(1, 0, 1, 0, 0, 16'h0, 3, 0, 1, "snd_rd");
      check_status("snd_rd");

      // Byte lanes
      bus_cycle(1, 1, 0, 0, 0, 16'hAAAA, 2, 0, 0, "rep_full");
      bus_cycle(1, 1, 0, 1, 0, 16'h5566, 2, 0, 0, "rep_lo");
      bus_cycle(0, 1, 1, 0, 0, 16'h0, 2, 0, 1, "main_rd1");
      check_status("lanes");

      // Long write cycle with din changing every clock commits once
      bus_cycle(0, 0, 0, 0, 0, 16'hC0DE, 20, 1, 0, "hold20");
      bus_cycle(1, 0, 1, 0, 0, 16'h0, 2, 1, 0, "rd_hold");
      bus_cycle(1, 0, 1, 1, 0, 16'h0, 2, 0, 0, "rd_again");
      check_status("two_reads");

      // Consumer read of latch0 ends in the clock the main write commits
      @(negedge clk);
      drive(1, 0, 1, 0, 0, 16'h0);
      model_read(1, 0, "coll_rd");
      $display("txn coll_rd    sound rd latch0");
      repeat (2) @(negedge clk);
      @(negedge clk);
      idle_sound();
      mdl_pend[0][0] = 0;
      drive(0, 0, 0, 0, 0, 16'h0F0F);
      model_write(0, 0, 0, 0, 16'h0F0F);
      $display("txn coll_wr    main  wr latch0 data=0f0f");
      @(negedge clk);
      idle_main();
      check_status("collision");
      bus_cycle(1, 0, 1, 0, 0, 16'h0, 1, 0, 0, "coll_chk");

      // Write and iack in the same clock
      bus_cycle(0, 0, 0, 0, 0, 16'h7777, 1, 0, 0, "arm_irq");
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 16'h3C3C);
      s_iack = 1;
      mdl_irq[0] = 0; mdl_irq[1] = 0;
      model_write(0, 0, 0, 0, 16'h3C3C);
      $display("txn wr_iack    main  wr latch0 data=3c3c with iack");
      @(negedge clk);
      idle_main();
      s_iack = 0;
      check_status("wr_iack");

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         side = 1'($urandom_range(0, 1));
         rw   = 1'($urandom_range(0, 1));
         lat  = rw ? 1'($urandom_range(0, 1)) : side;
         st   = $urandom_range(1, 3);
         bus_cycle(side, lat, rw, !st[1], !st[0], 16'($urandom),
                   $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), "rnd");
         if ($urandom_range(0, 3) == 0) iack_pulse();
         check_status("rnd");
      end

      repeat (5) @(negedge clk);
      if (rq_m.size() != 0 || rq_s.size() != 0 || sq.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: got %0d pending expected 0", rq_m.size() + rq_s.size() + sq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
